// File: rtl/fetch_stage_pkg.sv
// Shared fetch-side constants: PC step, reset PC default and instruction field widths.
// The field widths mirror the datapath's ALU_* decode and fix the default instruction width.
package fetch_stage_pkg;

    localparam int unsigned PC_STEP          = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned SHAMT_W  = 5;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned INSTR_W  = OPCODE_W + 3 * REG_W + SHAMT_W + FUNCT_W;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with flush, simultaneous push/pop and registered storage.
// Head entry is read straight from storage, so the consumer never sees a comb path from push_data.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != DEPTH_C) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited reads to a
// 1-cycle instruction memory, buffers returns and hands {instr, pc, pc+4} to decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned          WORD_SIZE  = INSTR_W,
    parameter int unsigned          ADDR_BITS  = 8,
    parameter int unsigned          FIFO_DEPTH = 2,
    parameter logic [WORD_SIZE-1:0] RESET_PC   = WORD_SIZE'(RESET_PC_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [ADDR_BITS-1:0] imem_addr,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_instr,
    output logic [WORD_SIZE-1:0] out_pc,
    output logic [WORD_SIZE-1:0] out_pc_plus4,
    output logic [WORD_SIZE-1:0] instr_count
);

    localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C  = (CW+1)'(FIFO_DEPTH);

    logic [WORD_SIZE-1:0]   fetch_pc_q, fetch_pc_d;
    logic [WORD_SIZE-1:0]   pc_inflight_q, pc_inflight_d;
    logic [WORD_SIZE-1:0]   instr_count_q, instr_count_d;
    logic                   inflight_q, inflight_d;
    logic                   fire, fifo_push, fifo_full, fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic [2*WORD_SIZE-1:0] head;
    logic [CW:0]            level, limit;
    logic [WORD_SIZE-1:0]   redirect_target;

    assign redirect_target = redirect_pc & ~WORD_SIZE'(3);
    assign out_valid       = !fifo_empty;
    assign fire            = out_valid && out_ready;
    assign fifo_push       = inflight_q && !redirect_valid;
    assign imem_addr       = fetch_pc_q[ADDR_BITS+1:2];

    // Credit: buffered + in-flight words, less the one leaving now, must stay below depth.
    always_comb begin
        level         = {1'b0, fifo_count} + (CW+1)'(inflight_q);
        limit         = DEPTH_C + (CW+1)'(fire);
        imem_req      = rst && !redirect_valid && !(fifo_full && !fire) && (level < limit);
        fetch_pc_d    = fetch_pc_q;
        pc_inflight_d = pc_inflight_q;
        inflight_d    = imem_req;
        instr_count_d = instr_count_q + WORD_SIZE'(fire);
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
        end else if (imem_req) begin
            pc_inflight_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + WORD_SIZE'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= {RESET_PC[WORD_SIZE-1:2], 2'b00};
            pc_inflight_q <= '0;
            instr_count_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            pc_inflight_q <= pc_inflight_d;
            instr_count_q <= instr_count_d;
            inflight_q    <= inflight_d;
        end
    end

    fetch_fifo #(
        .WIDTH (2 * WORD_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data ({imem_rdata, pc_inflight_q}),
        .pop       (fire),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_instr    = out_valid ? head[2*WORD_SIZE-1:WORD_SIZE] : '0;
    assign out_pc       = out_valid ? head[WORD_SIZE-1:0] : '0;
    assign out_pc_plus4 = out_valid ? head[WORD_SIZE-1:0] + WORD_SIZE'(PC_STEP) : '0;
    assign instr_count  = instr_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: scoreboard of expected {instr, pc} per delivered instruction,
// plus cycle-exact checks of request, latency, redirect, wrap and async reset behaviour.
module tb_fetch_stage;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    // DUT A: default RESET_PC
    logic        rst_a = 1'b0;
    logic        imem_req_a;
    logic [7:0]  imem_addr_a;
    logic [31:0] imem_rdata_a = '0;
    logic        redirect_valid_a = 1'b0;
    logic [31:0] redirect_pc_a = '0;
    logic        out_valid_a;
    logic        out_ready_a = 1'b0;
    logic [31:0] out_instr_a, out_pc_a, out_pc_plus4_a, instr_count_a;

    // DUT B: RESET_PC near the top of the address space
    logic        rst_b = 1'b0;
    logic        imem_req_b;
    logic [7:0]  imem_addr_b;
    logic [31:0] imem_rdata_b = '0;
    logic        redirect_valid_b = 1'b0;
    logic [31:0] redirect_pc_b = '0;
    logic        out_valid_b;
    logic        out_ready_b = 1'b1;
    logic [31:0] out_instr_b, out_pc_b, out_pc_plus4_b, instr_count_b;

    fetch_stage dut_a (
        .clk(clk), .rst(rst_a), .imem_req(imem_req_a), .imem_addr(imem_addr_a),
        .imem_rdata(imem_rdata_a), .redirect_valid(redirect_valid_a), .redirect_pc(redirect_pc_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_instr(out_instr_a),
        .out_pc(out_pc_a), .out_pc_plus4(out_pc_plus4_a), .instr_count(instr_count_a)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst(rst_b), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
        .imem_rdata(imem_rdata_b), .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_instr(out_instr_b),
        .out_pc(out_pc_b), .out_pc_plus4(out_pc_plus4_b), .instr_count(instr_count_b)
    );

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    always @(posedge clk) begin
        if (imem_req_a) imem_rdata_a <= mem_a[imem_addr_a];
        if (imem_req_b) imem_rdata_b <= mem_b[imem_addr_b];
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic void expect_from(input logic [31:0] start);
        logic [31:0] pc;
        sb.delete();
        for (int k = 0; k < 32; k++) begin
            pc = start + 32'(4 * k);
            sb.push_back('{mem_a[pc[9:2]], pc});
        end
    endfunction

    // Every handshake on DUT A must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_a && out_valid_a && out_ready_a) begin
            exp_t e;
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_instr", out_instr_a, e.instr);
                check("sb_pc", out_pc_a, e.pc);
                check("sb_pc_plus4", out_pc_plus4_a, e.pc + 32'd4);
            end
        end
    end

    task automatic wait_drv();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_neg();
        @(negedge clk);
    endtask

    task automatic cyc();
        wait_drv();
        wait_neg();
    endtask

    task automatic do_reset_a(input logic ready);
        wait_drv();
        rst_a = 1'b0;
        out_ready_a = ready;
        redirect_valid_a = 1'b0;
        redirect_pc_a = '0;
        expect_from(32'h0);
        wait_neg();
        check("rst_valid", 32'(out_valid_a), 32'd0);
        check("rst_req", 32'(imem_req_a), 32'd0);
        check("rst_instr", out_instr_a, 32'd0);
        check("rst_pc", out_pc_a, 32'd0);
        check("rst_pc_plus4", out_pc_plus4_a, 32'd0);
        check("rst_count", instr_count_a, 32'd0);
        wait_drv();
        rst_a = 1'b1;
        wait_neg();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
            mem_b[i] = 32'hB000_0000 ^ (32'(i) << 4);
        end
        mem_a[0] = 32'h2008_0005;
        mem_a[1] = 32'h2009_0007;
        mem_a[2] = 32'h0109_5020;
        mem_a[3] = 32'hAC0A_0000;

        // Reset release streaming: request at cycle 0, first delivery at cycle 2.
        do_reset_a(1'b1);
        check("t1_req_c0", 32'(imem_req_a), 32'd1);
        check("t1_addr_c0", 32'(imem_addr_a), 32'd0);
        check("t1_valid_c0", 32'(out_valid_a), 32'd0);
        cyc();
        check("t1_req_c1", 32'(imem_req_a), 32'd1);
        check("t1_addr_c1", 32'(imem_addr_a), 32'd1);
        check("t1_valid_c1", 32'(out_valid_a), 32'd0);
        for (int c = 2; c <= 6; c++) begin
            cyc();
            check("t1_stream_valid", 32'(out_valid_a), 32'd1);
            if (c == 2) begin
                check("t1_first_instr", out_instr_a, 32'h2008_0005);
                check("t1_first_pc", out_pc_a, 32'd0);
                check("t1_first_pc4", out_pc_plus4_a, 32'd4);
            end
        end
        check("t1_count", instr_count_a, 32'd4);

        // Backpressure from reset: exactly two requests, head holds.
        begin
            int unsigned nreq = 0;
            do_reset_a(1'b0);
            for (int c = 0; c <= 5; c++) begin
                if (imem_req_a) begin
                    check("t2_req_addr", 32'(imem_addr_a), 32'(nreq));
                    nreq++;
                end
                if (c >= 2) begin
                    check("t2_hold_valid", 32'(out_valid_a), 32'd1);
                    check("t2_hold_pc", out_pc_a, 32'd0);
                    check("t2_hold_instr", out_instr_a, 32'h2008_0005);
                end
                if (c < 5) cyc();
            end
            check("t2_nreq", nreq, 32'd2);
            wait_drv();
            out_ready_a = 1'b1;
            wait_neg();
            check("t2_resume_valid0", 32'(out_valid_a), 32'd1);
            cyc();
            check("t2_resume_valid1", 32'(out_valid_a), 32'd1);
            cyc();
            check("t2_resume_valid2", 32'(out_valid_a), 32'd1);
            check("t2_resume_pc2", out_pc_a, 32'd8);
        end

        // Redirect while streaming; the same-cycle fire still counts.
        do_reset_a(1'b1);
        for (int c = 1; c <= 5; c++) cyc();
        wait_drv();
        redirect_valid_a = 1'b1;
        redirect_pc_a = 32'h0000_0043;
        wait_neg();
        check("t3_req_redirect", 32'(imem_req_a), 32'd0);
        check("t3_fire_redirect", 32'(out_valid_a), 32'd1);
        wait_drv();
        redirect_valid_a = 1'b0;
        expect_from(32'h40);
        wait_neg();
        check("t3_count", instr_count_a, 32'd5);
        check("t3_valid_n1", 32'(out_valid_a), 32'd0);
        check("t3_req_n1", 32'(imem_req_a), 32'd1);
        check("t3_addr_n1", 32'(imem_addr_a), 32'h10);
        cyc();
        check("t3_valid_n2", 32'(out_valid_a), 32'd0);
        cyc();
        check("t3_valid_n3", 32'(out_valid_a), 32'd1);
        check("t3_pc_n3", out_pc_a, 32'h40);
        cyc();
        cyc();

        // Redirect over an in-flight response, then back-to-back redirects over a full FIFO.
        do_reset_a(1'b0);
        cyc();
        wait_drv();
        redirect_valid_a = 1'b1;
        redirect_pc_a = 32'h0000_0080;
        wait_neg();
        check("t4_req_redirect", 32'(imem_req_a), 32'd0);
        wait_drv();
        redirect_valid_a = 1'b0;
        expect_from(32'h80);
        wait_neg();
        check("t4_flushed_valid", 32'(out_valid_a), 32'd0);
        check("t4_req_n1", 32'(imem_req_a), 32'd1);
        check("t4_addr_n1", 32'(imem_addr_a), 32'h20);
        cyc();
        check("t4_valid_n2", 32'(out_valid_a), 32'd0);
        cyc();
        check("t4_valid_n3", 32'(out_valid_a), 32'd1);
        check("t4_pc_n3", out_pc_a, 32'h80);
        wait_drv();
        redirect_valid_a = 1'b1;
        redirect_pc_a = 32'h0000_0200;
        wait_neg();
        check("t4_req_b2b0", 32'(imem_req_a), 32'd0);
        wait_drv();
        redirect_pc_a = 32'h0000_0302;
        wait_neg();
        check("t4_req_b2b1", 32'(imem_req_a), 32'd0);
        wait_drv();
        redirect_valid_a = 1'b0;
        out_ready_a = 1'b1;
        expect_from(32'h300);
        wait_neg();
        check("t4_b2b_valid_n1", 32'(out_valid_a), 32'd0);
        check("t4_b2b_addr_n1", 32'(imem_addr_a), 32'hC0);
        cyc();
        cyc();
        check("t4_b2b_valid_n3", 32'(out_valid_a), 32'd1);
        check("t4_b2b_pc_n3", out_pc_a, 32'h300);
        check("t4_b2b_count", instr_count_a, 32'd0);
        cyc();
        cyc();

        // Reset mid-stream takes effect without a clock edge.
        do_reset_a(1'b1);
        for (int c = 1; c <= 4; c++) cyc();
        check("t6_pre_valid", 32'(out_valid_a), 32'd1);
        wait_drv();
        rst_a = 1'b0;
        #1;
        check("t6_async_valid", 32'(out_valid_a), 32'd0);
        check("t6_async_count", instr_count_a, 32'd0);
        check("t6_async_req", 32'(imem_req_a), 32'd0);
        expect_from(32'h0);
        wait_neg();
        wait_drv();
        rst_a = 1'b1;
        wait_neg();
        check("t6_restart_req", 32'(imem_req_a), 32'd1);
        check("t6_restart_addr", 32'(imem_addr_a), 32'd0);
        cyc();
        cyc();
        check("t6_restart_pc", out_pc_a, 32'd0);

        // Wrap-around on DUT B.
        wait_neg();
        check("t5_rst_valid", 32'(out_valid_b), 32'd0);
        check("t5_rst_req", 32'(imem_req_b), 32'd0);
        wait_drv();
        rst_b = 1'b1;
        wait_neg();
        check("t5_addr_c0", 32'(imem_addr_b), 32'hFE);
        check("t5_req_c0", 32'(imem_req_b), 32'd1);
        cyc();
        check("t5_addr_c1", 32'(imem_addr_b), 32'hFF);
        cyc();
        check("t5_addr_c2", 32'(imem_addr_b), 32'h00);
        check("t5_valid_c2", 32'(out_valid_b), 32'd1);
        check("t5_pc_c2", out_pc_b, 32'hFFFF_FFF8);
        check("t5_pc4_c2", out_pc_plus4_b, 32'hFFFF_FFFC);
        check("t5_instr_c2", out_instr_b, mem_b[8'hFE]);
        cyc();
        check("t5_pc_c3", out_pc_b, 32'hFFFF_FFFC);
        check("t5_pc4_c3", out_pc_plus4_b, 32'h0000_0000);
        check("t5_instr_c3", out_instr_b, mem_b[8'hFF]);
        cyc();
        check("t5_pc_c4", out_pc_b, 32'h0000_0000);
        check("t5_pc4_c4", out_pc_plus4_b, 32'h0000_0004);
        check("t5_instr_c4", out_instr_b, mem_b[8'h00]);
        check("t5_count_c4", instr_count_b, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
